// File: rtl/divider_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding, default sizes
// and an index-width helper.
package divider_arbiter_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Handshake between the arbiter and the shared divider it feeds.
interface divider_arbiter_if
  import divider_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             div_req;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_ack;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport master (
    output div_req, div_dividend, div_divisor,
    input  div_ack, div_quotient, div_remainder
  );

  modport slave (
    input  div_req, div_dividend, div_divisor,
    output div_ack, div_quotient, div_remainder
  );
endinterface

// File: rtl/divider_rr_pick.sv
// Round-robin selector: first asserted request at or after the pointer.
module divider_rr_pick
  import divider_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [2*NREQ-1:0] rot;
  logic [IDX_W-1:0]  offset;
  logic [IDX_W:0]    sum;

  // Doubling the vector lets a plain shift express the rotation.
  assign rot = {req, req} >> pointer;

  always_comb begin
    valid  = |req;
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = IDX_W'(k);
    end
    sum = {1'b0, pointer} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
    index = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one external divider among NREQ requesters with round-robin
// arbitration, divide-by-zero bypass and a bounded wait for the divider.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dividend_in,
  input  logic [NREQ*WIDTH-1:0] divisor_in,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  dz,
  output logic                  tmo,
  output logic                  busy,
  divider_arbiter_if.master     div
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dz_reg, dz_next;
  logic             tmo_reg, tmo_next;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_index;
  logic [WIDTH-1:0] dividend_arr [NREQ];
  logic [WIDTH-1:0] divisor_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign dividend_arr[gi] = dividend_in[gi*WIDTH +: WIDTH];
    assign divisor_arr[gi]  = divisor_in[gi*WIDTH +: WIDTH];
    assign ack[gi] = (state_reg == DONE) && (grant_reg == IDX_W'(gi));
  end

  divider_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .pointer (ptr_reg),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dz_next        = dz_reg;
    tmo_next       = tmo_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next    = pick_index;
          dividend_next = dividend_arr[pick_index];
          divisor_next  = divisor_arr[pick_index];
          // A zero divisor never reaches the divider.
          if (divisor_arr[pick_index] == '0) begin
            quotient_next  = '1;
            remainder_next = dividend_arr[pick_index];
            dz_next        = 1'b1;
            tmo_next       = 1'b0;
            state_next     = DONE;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (div.div_ack) begin
          quotient_next  = div.div_quotient;
          remainder_next = div.div_remainder;
          dz_next        = 1'b0;
          tmo_next       = 1'b0;
          state_next     = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          quotient_next  = '0;
          remainder_next = '0;
          dz_next        = 1'b0;
          tmo_next       = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        ptr_next   = (grant_reg == IDX_W'(NREQ - 1)) ? '0 : grant_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
      tmo_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dz_reg        <= dz_next;
      tmo_reg       <= tmo_next;
    end
  end

  assign quotient         = quotient_reg;
  assign remainder        = remainder_reg;
  assign dz               = dz_reg;
  assign tmo              = tmo_reg;
  assign busy             = (state_reg != IDLE);
  assign div.div_req      = (state_reg == ISSUE);
  assign div.div_dividend = dividend_reg;
  assign div.div_divisor  = divisor_reg;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter; the bench itself plays the shared
// divider and the requesters.
module tb_divider_arbiter;
  import divider_arbiter_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] dividend_in;
  logic [N*W-1:0] divisor_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           dz;
  logic           tmo;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  divider_arbiter_if #(.WIDTH(W)) div_if ();

  divider_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .ack         (ack),
    .quotient    (quotient),
    .remainder   (remainder),
    .dz          (dz),
    .tmo         (tmo),
    .busy        (busy),
    .div         (div_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend_in[i*W +: W] = a;
    divisor_in[i*W +: W]  = b;
  endtask

  // Wait (bounded) for div_req, then answer one cycle into WAIT; returns in DONE.
  task automatic divider_respond(input logic [W-1:0] q, input logic [W-1:0] r,
                                 output logic [W-1:0] seen_dividend);
    int n = 0;
    while (div_if.div_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("div_req_seen", {31'd0, div_if.div_req}, 32'd1);
    seen_dividend = div_if.div_dividend;
    tick();
    div_if.div_ack       = 1'b1;
    div_if.div_quotient  = q;
    div_if.div_remainder = r;
    tick();
    div_if.div_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seen;
    int           n;

    req = '0;
    dividend_in = '0;
    divisor_in = '0;
    div_if.div_ack = 1'b0;
    div_if.div_quotient = '0;
    div_if.div_remainder = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_div_req", {31'd0, div_if.div_req}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    chk("rst_ptr", {30'd0, dut.ptr_reg}, 32'd0);
    chk("rst_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    reset_n = 1'b1;
    tick();

    // 100 / 7 on requester 1
    set_op(1, 8'd100, 8'd7);
    req = 4'b0010;
    tick();
    chk("t1_div_req", {31'd0, div_if.div_req}, 32'd1);
    chk("t1_div_dividend", {24'd0, div_if.div_dividend}, 32'd100);
    chk("t1_div_divisor", {24'd0, div_if.div_divisor}, 32'd7);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_div_req_one_cycle", {31'd0, div_if.div_req}, 32'd0);
    chk("t1_hold_dividend", {24'd0, div_if.div_dividend}, 32'd100);
    chk("t1_hold_divisor", {24'd0, div_if.div_divisor}, 32'd7);
    chk("t1_no_early_ack", {28'd0, ack}, 32'd0);
    div_if.div_ack = 1'b1;
    div_if.div_quotient = 8'd14;
    div_if.div_remainder = 8'd2;
    tick();
    div_if.div_ack = 1'b0;
    chk("t1_ack", {28'd0, ack}, 32'b0010);
    chk("t1_quotient", {24'd0, quotient}, 32'd14);
    chk("t1_remainder", {24'd0, remainder}, 32'd2);
    chk("t1_dz", {31'd0, dz}, 32'd0);
    chk("t1_tmo", {31'd0, tmo}, 32'd0);
    req = 4'b0000;
    tick();
    chk("t1_ack_pulse", {28'd0, ack}, 32'd0);
    chk("t1_quotient_hold", {24'd0, quotient}, 32'd14);
    chk("t1_ptr", {30'd0, dut.ptr_reg}, 32'd2);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Requesters 0 and 2 together from pointer 0
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t2_ptr_start", {30'd0, dut.ptr_reg}, 32'd0);
    set_op(0, 8'd20, 8'd3);
    set_op(2, 8'd9, 8'd4);
    req = 4'b0101;
    divider_respond(8'd6, 8'd2, seen);
    chk("t2_first_dividend", {24'd0, seen}, 32'd20);
    chk("t2_first_ack", {28'd0, ack}, 32'b0001);
    chk("t2_first_quotient", {24'd0, quotient}, 32'd6);
    req = 4'b0100;
    divider_respond(8'd2, 8'd1, seen);
    chk("t2_second_dividend", {24'd0, seen}, 32'd9);
    chk("t2_second_ack", {28'd0, ack}, 32'b0100);
    chk("t2_second_remainder", {24'd0, remainder}, 32'd1);
    req = 4'b0000;
    tick();
    chk("t2_ptr_end", {30'd0, dut.ptr_reg}, 32'd3);

    // 42 / 0 on requester 3: bypass the divider
    set_op(3, 8'd42, 8'd0);
    req = 4'b1000;
    chk("t3_no_ack_before_grant", {28'd0, ack}, 32'd0);
    tick();
    chk("t3_ack", {28'd0, ack}, 32'b1000);
    chk("t3_no_div_req", {31'd0, div_if.div_req}, 32'd0);
    chk("t3_quotient", {24'd0, quotient}, 32'd255);
    chk("t3_remainder", {24'd0, remainder}, 32'd42);
    chk("t3_dz", {31'd0, dz}, 32'd1);
    chk("t3_tmo", {31'd0, tmo}, 32'd0);
    req = 4'b0000;
    tick();
    chk("t3_ptr_wrap", {30'd0, dut.ptr_reg}, 32'd0);
    chk("t3_dz_hold", {31'd0, dz}, 32'd1);

    // Divider never answers: timeout after 64 WAIT cycles
    set_op(0, 8'd50, 8'd5);
    req = 4'b0001;
    tick();
    chk("t4_div_req", {31'd0, div_if.div_req}, 32'd1);
    tick();
    n = 0;
    while (ack == '0 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_wait_cycles", n, 32'd64);
    chk("t4_ack", {28'd0, ack}, 32'b0001);
    chk("t4_tmo", {31'd0, tmo}, 32'd1);
    chk("t4_quotient", {24'd0, quotient}, 32'd0);
    chk("t4_remainder", {24'd0, remainder}, 32'd0);
    chk("t4_dz", {31'd0, dz}, 32'd0);
    req = 4'b0000;
    tick();

    // Stray div_ack while idle
    div_if.div_ack = 1'b1;
    div_if.div_quotient = 8'd77;
    tick();
    div_if.div_ack = 1'b0;
    chk("t4_stray_busy", {31'd0, busy}, 32'd0);
    chk("t4_stray_ack", {28'd0, ack}, 32'd0);
    chk("t4_stray_quotient", {24'd0, quotient}, 32'd0);

    // Reset during WAIT, then a late div_ack
    set_op(1, 8'd100, 8'd7);
    req = 4'b0010;
    tick();
    tick();
    chk("t5_in_wait", {30'd0, dut.state_reg}, {30'd0, WAIT});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b0000;
    chk("t5_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    chk("t5_ptr", {30'd0, dut.ptr_reg}, 32'd0);
    div_if.div_ack = 1'b1;
    div_if.div_quotient = 8'd14;
    div_if.div_remainder = 8'd2;
    tick();
    div_if.div_ack = 1'b0;
    chk("t5_no_ack", {28'd0, ack}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_quotient", {24'd0, quotient}, 32'd0);
    tick();
    chk("t5_no_ack_later", {28'd0, ack}, 32'd0);

    // All four held high: grants 0,1,2,3,0
    for (int i = 0; i < N; i++) set_op(i, W'(10 * (i + 1)), 8'd3);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      divider_respond(W'(k + 1), W'(k), seen);
      chk("t6_rr_ack", {28'd0, ack}, 32'd1 << (k % 4));
      chk("t6_rr_dividend", {24'd0, seen}, 32'(10 * ((k % 4) + 1)));
      chk("t6_rr_quotient", {24'd0, quotient}, 32'(k + 1));
    end
    req = 4'b0000;
    tick();
    tick();
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
